light_grid_engine: RTL
======================

# light_grid_engine

Consumes normalized instructions from `line_decoder` and applies each one as a rectangular update to an on-chip light grid (turn on / turn off / toggle). After `end_of_file`, it scans the whole grid and reports the number of lit lights. It sits directly downstream of `line_decoder` and drives the puzzle result to the top-level result sink. A small input FIFO absorbs decoder bursts, because the decoder has no back-pressure.

## Interface
- `INSTRUCTION_WIDTH`, default 44: width of the instruction word. Layout is `[43]` last, `[42]` valid, `[41:40]` op, `[39:30]` start_row, `[29:20]` start_col, `[19:10]` end_row, `[9:0]` end_col.
- `GRID_SIZE`, default 1000: rows and columns of the square grid.
- `WORD_WIDTH`, default 32: bits per memory word.
- `FIFO_DEPTH`, default 16: depth of the instruction FIFO. Must be a power of two.
- `RESULT_WIDTH`, default 20: width of the lit-light count. Must hold GRID_SIZE².
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `end_of_file` in 1: single-cycle pulse from the decoder after the last instruction.
- `normalized_instr_valid` in 1: push strobe for the FIFO.
- `normalized_instr_data` in INSTRUCTION_WIDTH: instruction word.
- `busy` out 1: high whenever the FSM is not in IDLE or DONE.
- `overflow_error` out 1: sticky; set when a push arrives while the FIFO is full.
- `result_valid` out 1: level signal; high in DONE.
- `result_data` out RESULT_WIDTH: lit-light count, stable while `result_valid` is high.

## Operation
- Op encoding:
  - 2'b00: turn off
  - 2'b01: turn on
  - 2'b10: toggle
  - 2'b11: no-op (FIFO entry is consumed, grid untouched)
- Grid storage:
  - WPR = ceil(GRID_SIZE/WORD_WIDTH), rounded up to a power of two.
  - Memory depth is GRID_SIZE×WPR, single-port, synchronous read with 1-cycle latency.
  - Address is `{row, word_idx}`; bit b of word w represents column w×WORD_WIDTH+b.
  - Padding bits (column ≥ GRID_SIZE) are never set.
- Rectangle normalization on LOAD:
  - r0=min(start_row,end_row), r1=max(start_row,end_row); c0/c1 likewise for columns.
  - Coordinates ≥ GRID_SIZE are clamped to GRID_SIZE-1.
- Column mask for word w: bit b is set when c0 ≤ w×WORD_WIDTH+b ≤ c1.
- Word update:
  - off: `q & ~m`
  - on: `q | m`
  - toggle: `q ^ m`
- FSM states and transitions:
  - CLEAR → IDLE.
  - IDLE → LOAD when the FIFO is not empty.
  - IDLE → COUNT_RD when the EOF latch is set and the FIFO is empty.
  - LOAD: pop the FIFO, latch op/r0/r1/c0/c1, set row=r0 and word=c0/WORD_WIDTH. Go to READ; go to IDLE if the op is no-op.
  - READ: issue a read of `{row, word}`, then go to WRITE.
  - WRITE: write the modified word. Then step to the next word, or wrap to the next row at word=c0/WORD_WIDTH. Go to IDLE after the last word of row r1.
  - COUNT_RD / COUNT_ACC: walk every address from 0 upward, accumulating popcount(q) into the counter, then go to DONE.
  - DONE: terminal until reset.
- EOF latch: set by an `end_of_file` pulse in any state. An instruction with bit[43] set also sets it on pop. Cleared only by reset.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - A push while full without a simultaneous pop is dropped and sets `overflow_error`.
- Pushes arriving in DONE are ignored. They do not set the error.

## Timing
- Reset values:
  - `busy`=1 if LIGHT_GRID_CLEAR_EN is defined, otherwise 0.
  - `overflow_error`=0, `result_valid`=0, `result_data`=0.
  - FSM enters CLEAR or IDLE; FIFO empty; EOF latch clear.
- Per instruction: 1 LOAD cycle plus 2 cycles per touched word (READ+WRITE). There is no read/write overlap, so no RAW hazard arises across instructions.
- A full-grid instruction with defaults takes 1+2×1000×32 = 64001 cycles.
- Count phase: 2 cycles per address. `result_valid` rises the cycle after the final COUNT_ACC.
- A push is visible to IDLE on the following cycle, giving 2 cycles of latency from push to LOAD.
- Asserting `reset` mid-operation abandons all work immediately. Grid contents are undefined unless they are re-cleared.

## Configuration
- `LIGHT_GRID_CLEAR_EN` defined:
  - After reset the FSM enters CLEAR and writes zero to all GRID_SIZE×WPR words, one per cycle, with `busy`=1.
  - Pushes arriving during CLEAR are buffered in the FIFO.
- `LIGHT_GRID_CLEAR_EN` undefined:
  - There is no CLEAR state; reset goes straight to IDLE.
  - The grid relies on memory initialization to zero, so it is valid only for the first run after configuration.

## Test plan
- Full-grid on: "on 0,0→999,999" then EOF → `result_data`=1000000, `result_valid`=1.
- Mixed ops: "on 0,0→999,999", "toggle 0,0→999,0", "off 499,499→500,500" → 998996.
- Reversed coordinates and unaligned mask: "on 999,40→0,31" (10 columns, one word boundary crossed) → 10000. A no-op op=3 entry leaves the count unchanged.
- Overflow: FIFO_DEPTH=4, push 6 back-to-back instructions during a long toggle → `overflow_error`=1 and exactly 4 instructions are applied. A push plus pop at full does not set the error.
- Small grid: GRID_SIZE=8, WORD_WIDTH=4, toggle 1,1→6,6 twice, then on 0,0→0,7 → 8. Padding bits stay 0.
- Reset mid-operation: assert `reset` during WRITE → all outputs return to reset values. A rerun of "on 0,0→1,1" gives 4 with LIGHT_GRID_CLEAR_EN defined.

Source files
------------

// File: rtl/light_grid_if.sv
// light_grid_if: bundle between the instruction decoder and light_grid_engine.
// The master drives the instruction stream and end-of-file pulse.
// The slave (the engine) returns status and the lit-light count.
interface light_grid_if #(
    parameter int INSTRUCTION_WIDTH = 44,
    parameter int RESULT_WIDTH      = 20
);
    logic                         end_of_file;
    logic                         normalized_instr_valid;
    logic [INSTRUCTION_WIDTH-1:0] normalized_instr_data;
    logic                         busy;
    logic                         overflow_error;
    logic                         result_valid;
    logic [RESULT_WIDTH-1:0]      result_data;

    modport master (
        output end_of_file, normalized_instr_valid, normalized_instr_data,
        input  busy, overflow_error, result_valid, result_data
    );

    modport slave (
        input  end_of_file, normalized_instr_valid, normalized_instr_data,
        output busy, overflow_error, result_valid, result_data
    );
endinterface

// File: rtl/light_grid_engine.sv
// light_grid_engine: applies rectangular on/off/toggle updates to an on-chip
// light grid and, after end of file, counts the lit lights.
// Optional feature macro: LIGHT_GRID_CLEAR_EN adds a CLEAR state that zeroes
// the whole grid after reset. Without it, the grid relies on memory power-up
// contents being zero.
module light_grid_engine #(
    parameter int INSTRUCTION_WIDTH = 44,
    parameter int GRID_SIZE         = 1000,
    parameter int WORD_WIDTH        = 32,
    parameter int FIFO_DEPTH        = 16,
    parameter int RESULT_WIDTH      = 20
) (
    input  logic        clk,
    input  logic        reset,
    light_grid_if.slave bus
);
    localparam int WPR_RAW    = (GRID_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int WORD_IDX_W = (WPR_RAW > 1) ? $clog2(WPR_RAW) : 1;
    localparam int WPR        = 1 << WORD_IDX_W;
    localparam int ROW_W      = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
    localparam int ADDR_W     = ROW_W + WORD_IDX_W;
    localparam int MEM_DEPTH  = GRID_SIZE * WPR;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COORD_W    = 10;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [COORD_W-1:0] MAX_COORD = COORD_W'(GRID_SIZE - 1);

    typedef enum logic [2:0] {
`ifdef LIGHT_GRID_CLEAR_EN
        ST_CLEAR,
`endif
        ST_IDLE, ST_LOAD, ST_READ, ST_WRITE, ST_COUNT_RD, ST_COUNT_ACC, ST_DONE
    } state_t;

    // Coordinates beyond the grid edge are pinned to the last row/column.
    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] x);
        if (32'(x) >= 32'(GRID_SIZE)) begin
            return MAX_COORD;
        end else begin
            return x;
        end
    endfunction

    function automatic logic [RESULT_WIDTH-1:0] popcount(input logic [WORD_WIDTH-1:0] w);
        logic [RESULT_WIDTH-1:0] n;
        n = {RESULT_WIDTH{1'b0}};
        for (int i = 0; i < WORD_WIDTH; i++) begin
            n = n + RESULT_WIDTH'(w[i]);
        end
        return n;
    endfunction

    state_t                       state_r;
    logic [INSTRUCTION_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]               fifo_cnt_r;
    logic                         eof_r;
    logic [1:0]                   op_r;
    logic [ROW_W-1:0]             row_r, r1_r;
    logic [WORD_IDX_W-1:0]        word_r, word_first_r, word_last_r;
    logic [COORD_W-1:0]           c0_r, c1_r;
    logic [ADDR_W-1:0]            walk_addr_r;
    logic [RESULT_WIDTH-1:0]      acc_r;
    logic [WORD_WIDTH-1:0]        grid_mem_r [MEM_DEPTH];
    logic [WORD_WIDTH-1:0]        rd_q_r;
    logic                         busy_r, overflow_r, result_valid_r;
    logic [RESULT_WIDTH-1:0]      result_data_r;

    logic [INSTRUCTION_WIDTH-1:0] head_s;
    logic                         fifo_empty_s, fifo_full_s, push_s, pop_s, push_ok_s;
    logic                         head_noop_s;
    logic [COORD_W-1:0]           r0_n_s, r1_n_s, c0_n_s, c1_n_s;
    logic [WORD_IDX_W-1:0]        w_first_s, w_last_s;
    logic [31:0]                  col_base_s;
    logic [WORD_WIDTH-1:0]        mask_s, new_word_s, mem_wdata_s;
    logic [ADDR_W-1:0]            mem_addr_s;
    logic                         mem_we_s;

    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign fifo_empty_s = (fifo_cnt_r == (PTR_W+1)'(1'b0));
    assign fifo_full_s  = (fifo_cnt_r == (PTR_W+1)'(FIFO_DEPTH));
    assign pop_s        = (state_r == ST_LOAD);
    assign push_s       = bus.normalized_instr_valid && (state_r != ST_DONE);
    // A full FIFO still accepts a push in the same cycle as a pop.
    assign push_ok_s    = push_s && (!fifo_full_s || pop_s);
    // An entry whose valid bit is clear is consumed like a no-op.
    assign head_noop_s  = (head_s[41:40] == 2'b11) || !head_s[42];
    assign w_first_s    = WORD_IDX_W'(32'(c0_n_s) / 32'(WORD_WIDTH));
    assign w_last_s     = WORD_IDX_W'(32'(c1_n_s) / 32'(WORD_WIDTH));
    assign col_base_s   = 32'(word_r) * 32'(WORD_WIDTH);

    assign bus.busy           = busy_r;
    assign bus.overflow_error = overflow_r;
    assign bus.result_valid   = result_valid_r;
    assign bus.result_data    = result_data_r;

    // Normalize the head rectangle: order corners, then clamp to the grid.
    always_comb begin
        r0_n_s = clamp_coord(head_s[39:30]);
        r1_n_s = clamp_coord(head_s[19:10]);
        c0_n_s = clamp_coord(head_s[29:20]);
        c1_n_s = clamp_coord(head_s[9:0]);
        if (head_s[39:30] > head_s[19:10]) begin
            r0_n_s = clamp_coord(head_s[19:10]);
            r1_n_s = clamp_coord(head_s[39:30]);
        end else begin
            r0_n_s = clamp_coord(head_s[39:30]);
            r1_n_s = clamp_coord(head_s[19:10]);
        end
        if (head_s[29:20] > head_s[9:0]) begin
            c0_n_s = clamp_coord(head_s[9:0]);
            c1_n_s = clamp_coord(head_s[29:20]);
        end else begin
            c0_n_s = clamp_coord(head_s[29:20]);
            c1_n_s = clamp_coord(head_s[9:0]);
        end
    end

    // Column mask for the current word and the resulting updated word.
    always_comb begin
        mask_s = {WORD_WIDTH{1'b0}};
        for (int b = 0; b < WORD_WIDTH; b++) begin
            mask_s[b] = ((col_base_s + 32'(b)) >= 32'(c0_r)) &&
                        ((col_base_s + 32'(b)) <= 32'(c1_r));
        end
        case (op_r)
            2'b00:   new_word_s = rd_q_r & ~mask_s;
            2'b01:   new_word_s = rd_q_r | mask_s;
            2'b10:   new_word_s = rd_q_r ^ mask_s;
            default: new_word_s = rd_q_r;
        endcase
    end

    // Grid RAM port control: walk address in CLEAR/COUNT, rectangle address otherwise.
    always_comb begin
        mem_addr_s  = {row_r, word_r};
        mem_we_s    = 1'b0;
        mem_wdata_s = new_word_s;
        case (state_r)
`ifdef LIGHT_GRID_CLEAR_EN
            ST_CLEAR: begin
                mem_addr_s  = walk_addr_r;
                mem_we_s    = 1'b1;
                mem_wdata_s = {WORD_WIDTH{1'b0}};
            end
`endif
            ST_WRITE:    mem_we_s   = 1'b1;
            ST_COUNT_RD: mem_addr_s = walk_addr_r;
            default:     mem_we_s   = 1'b0;
        endcase
    end

    // Single-port grid RAM with one-cycle registered read.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            grid_mem_r[mem_addr_s] <= mem_wdata_s;
        end
        rd_q_r <= grid_mem_r[mem_addr_s];
    end

    // Instruction FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= bus.normalized_instr_data;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= PTR_W'(1'b0);
            rd_ptr_r   <= PTR_W'(1'b0);
            fifo_cnt_r <= (PTR_W+1)'(1'b0);
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (PTR_W+1)'(1'b1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (PTR_W+1)'(1'b1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (push_s && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Control FSM: instruction sequencing, rectangle walk, count phase, result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef LIGHT_GRID_CLEAR_EN
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
`else
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
`endif
            eof_r          <= 1'b0;
            op_r           <= 2'b11;
            row_r          <= ROW_W'(1'b0);
            r1_r           <= ROW_W'(1'b0);
            word_r         <= WORD_IDX_W'(1'b0);
            word_first_r   <= WORD_IDX_W'(1'b0);
            word_last_r    <= WORD_IDX_W'(1'b0);
            c0_r           <= COORD_W'(1'b0);
            c1_r           <= COORD_W'(1'b0);
            walk_addr_r    <= ADDR_W'(1'b0);
            acc_r          <= RESULT_WIDTH'(1'b0);
            result_valid_r <= 1'b0;
            result_data_r  <= RESULT_WIDTH'(1'b0);
        end else begin
            if (bus.end_of_file || (pop_s && head_s[INSTRUCTION_WIDTH-1])) begin
                eof_r <= 1'b1;
            end
            case (state_r)
`ifdef LIGHT_GRID_CLEAR_EN
                ST_CLEAR: begin
                    if (walk_addr_r == LAST_ADDR) begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        walk_addr_r <= ADDR_W'(1'b0);
                    end else begin
                        walk_addr_r <= walk_addr_r + ADDR_W'(1'b1);
                    end
                end
`endif
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end else if (eof_r) begin
                        state_r     <= ST_COUNT_RD;
                        busy_r      <= 1'b1;
                        walk_addr_r <= ADDR_W'(1'b0);
                        acc_r       <= RESULT_WIDTH'(1'b0);
                    end
                end
                ST_LOAD: begin
                    op_r         <= head_s[41:40];
                    row_r        <= ROW_W'(r0_n_s);
                    r1_r         <= ROW_W'(r1_n_s);
                    c0_r         <= c0_n_s;
                    c1_r         <= c1_n_s;
                    word_r       <= w_first_s;
                    word_first_r <= w_first_s;
                    word_last_r  <= w_last_s;
                    if (head_noop_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_READ;
                    end
                end
                ST_READ: state_r <= ST_WRITE;
                ST_WRITE: begin
                    if (word_r != word_last_r) begin
                        word_r  <= word_r + WORD_IDX_W'(1'b1);
                        state_r <= ST_READ;
                    end else if (row_r != r1_r) begin
                        row_r   <= row_r + ROW_W'(1'b1);
                        word_r  <= word_first_r;
                        state_r <= ST_READ;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_COUNT_RD: state_r <= ST_COUNT_ACC;
                ST_COUNT_ACC: begin
                    acc_r <= acc_r + popcount(rd_q_r);
                    if (walk_addr_r == LAST_ADDR) begin
                        state_r        <= ST_DONE;
                        busy_r         <= 1'b0;
                        result_valid_r <= 1'b1;
                        result_data_r  <= acc_r + popcount(rd_q_r);
                    end else begin
                        walk_addr_r <= walk_addr_r + ADDR_W'(1'b1);
                        state_r     <= ST_COUNT_RD;
                    end
                end
                ST_DONE: state_r <= ST_DONE;
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
